montgomery_mult_param: RTL and testbench



---
 rtl/montgomery_mult_param.sv | 117 +++++++++++
 tb/tb_montgomery_mult_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/montgomery_mult_param.sv
// Digit-serial Montgomery multiplier: result = A*B*2^(-WIDTH) mod M, with
// DIGIT_BITS radix-2 steps unrolled per cycle and an even-modulus error path.
module montgomery_mult_param #(
    parameter int WIDTH      = 1024,
    parameter int DIGIT_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam int N     = WIDTH / DIGIT_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOOP  = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH+1:0] c_reg;
    logic [WIDTH+1:0] c_next;
    logic [WIDTH+1:0] c_sub;
    logic [WIDTH-1:0] reduced;
    logic [CNT_W-1:0] cnt;
    logic             err_pend;

    // C stays below 2M, so C + B + M fits in WIDTH+2 bits before each halving
    always_comb begin
        c_next = c_reg;
        for (int j = 0; j < DIGIT_BITS; j++) begin
            if (a_reg[j]) begin
                c_next = c_next + {2'b00, b_reg};
            end
            if (c_next[0]) begin
                c_next = c_next + {2'b00, m_reg};
            end
            c_next = c_next >> 1;
        end
    end

    always_comb begin
        c_sub   = c_reg - {2'b00, m_reg};
        reduced = (c_reg >= {2'b00, m_reg}) ? c_sub[WIDTH-1:0] : c_reg[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            m_reg    <= '0;
            c_reg    <= '0;
            cnt      <= '0;
            err_pend <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // an even modulus reports its error one edge after capture
                    if (err_pend) begin
                        err_pend <= 1'b0;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        result   <= '0;
                    end else if (start) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        m_reg <= in_m;
                        c_reg <= '0;
                        cnt   <= '0;
                        err   <= 1'b0;
                        if (in_m[0]) begin
                            state <= LOOP;
                        end else begin
                            err_pend <= 1'b1;
                        end
                    end
                end
                LOOP: begin
                    busy  <= 1'b1;
                    c_reg <= c_next;
                    a_reg <= a_reg >> DIGIT_BITS;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    result <= reduced;
                    done   <= 1'b1;
                    err    <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_mult_param.sv
// Bench for montgomery_mult_param: a 4-bit/radix-2 and an 8-bit/radix-4 instance
// checked against a brute-force modular-inverse reference model.
module tb_montgomery_mult_param;

    logic       clk;
    logic       reset;
    logic       start4;
    logic [3:0] in_a4, in_b4, in_m4, result4;
    logic       done4, busy4, err4;
    logic       start8;
    logic [7:0] in_a8, in_b8, in_m8, result8;
    logic       done8, busy8, err8;

    int pass_count;
    int check_count;

    montgomery_mult_param #(.WIDTH(4), .DIGIT_BITS(1)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .in_a(in_a4), .in_b(in_b4), .in_m(in_m4),
        .result(result4), .done(done4), .busy(busy4), .err(err4)
    );

    montgomery_mult_param #(.WIDTH(8), .DIGIT_BITS(2)) dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .in_a(in_a8), .in_b(in_b8), .in_m(in_m8),
        .result(result8), .done(done8), .busy(busy8), .err(err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the unique r < m with r * 2^w == a * b (mod m), found by search
    function automatic int mont_ref(input int a, input int b, input int m, input int w);
        int target;
        target = (a * b) % m;
        for (int r = 0; r < m; r++) begin
            if (((r << w) % m) == target) return r;
        end
        return -1;
    endfunction

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input int a, input int b, input int m);
        if (sel == 0) begin
            in_a4  = a[3:0];
            in_b4  = b[3:0];
            in_m4  = m[3:0];
            start4 = 1'b1;
        end else begin
            in_a8  = a[7:0];
            in_b8  = b[7:0];
            in_m8  = m[7:0];
            start8 = 1'b1;
        end
        wait_cycle();
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    // Returns lat=0 when no done arrives within the cycle budget
    task automatic wait_done(input int sel, output int lat, output int busy_cnt,
                             output int res, output logic er, output logic bz);
        lat      = 0;
        busy_cnt = 0;
        res      = 0;
        er       = 1'b0;
        bz       = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            wait_cycle();
            if ((sel == 0) ? done4 : done8) begin
                lat = k;
                res = (sel == 0) ? int'(result4) : int'(result8);
                er  = (sel == 0) ? err4 : err8;
                bz  = (sel == 0) ? busy4 : busy8;
                break;
            end
            if ((sel == 0) ? busy4 : busy8) busy_cnt++;
        end
    endtask

    task automatic run_op(input string tag, input int sel, input int a, input int b, input int m);
        int   lat, bcnt, res, n, w;
        logic er, bz;
        w = (sel == 0) ? 4 : 8;
        n = (sel == 0) ? 4 : 4;
        applyStimulus(sel, a, b, m);
        wait_done(sel, lat, bcnt, res, er, bz);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(n + 1));
        checkOutput({tag, "_result"}, 64'(res), 64'(mont_ref(a, b, m, w)));
        checkOutput({tag, "_err"}, {63'd0, er}, 64'd0);
        checkOutput({tag, "_busy_cycles"}, 64'(bcnt), 64'(n));
        checkOutput({tag, "_busy_at_done"}, {63'd0, bz}, 64'd0);
    endtask

    initial begin
        int   lat, bcnt, res, a, b, m, dones;
        logic er, bz;
        pass_count  = 0;
        check_count = 0;
        reset  = 1'b1;
        start4 = 1'b0;
        start8 = 1'b0;
        in_a4 = '0; in_b4 = '0; in_m4 = '0;
        in_a8 = '0; in_b8 = '0; in_m8 = '0;
        wait_cycle();
        wait_cycle();
        checkOutput("reset_result", {60'd0, result4}, 64'd0);
        checkOutput("reset_flags", {61'd0, done4, busy4, err4}, 64'd0);
        checkOutput("reset_flags8", {61'd0, done8, busy8, err8}, 64'd0);
        reset = 1'b0;

        run_op("m13_3x5", 0, 3, 5, 13);
        checkOutput("m13_3x5_value", {60'd0, result4}, 64'd5);
        wait_cycle();
        checkOutput("done_single_pulse", {63'd0, done4}, 64'd0);

        run_op("m15_14x14", 0, 14, 14, 15);
        checkOutput("m15_14x14_value", {60'd0, result4}, 64'd1);

        // Even modulus: error reported one cycle later, busy never rises
        applyStimulus(0, 3, 5, 12);
        wait_done(0, lat, bcnt, res, er, bz);
        checkOutput("even_latency", 64'(lat), 64'd1);
        checkOutput("even_err", {63'd0, er}, 64'd1);
        checkOutput("even_result", 64'(res), 64'd0);
        checkOutput("even_busy", 64'(bcnt) + {63'd0, bz}, 64'd0);
        run_op("after_even", 0, 3, 5, 13);

        // Ignored start mid-operation plus input changes after capture
        applyStimulus(0, 3, 5, 13);
        in_a4 = 4'd1;
        in_b4 = 4'd1;
        wait_cycle();
        start4 = 1'b1;
        wait_cycle();
        start4 = 1'b0;
        wait_done(0, lat, bcnt, res, er, bz);
        checkOutput("ignored_start_latency", 64'(lat), 64'd3);
        checkOutput("ignored_start_result", 64'(res), 64'd5);
        // Start in the done cycle is accepted back-to-back
        run_op("back_to_back", 0, 1, 1, 13);
        checkOutput("back_to_back_value", {60'd0, result4}, 64'd9);

        run_op("m239_1x1", 1, 1, 1, 239);
        checkOutput("m239_1x1_value", {56'd0, result8}, 64'd225);

        // Reset mid-operation clears outputs immediately and suppresses done
        applyStimulus(1, 5, 7, 239);
        wait_cycle();
        wait_cycle();
        checkOutput("busy_before_abort", {63'd0, busy8}, 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort_result", {56'd0, result8}, 64'd0);
        checkOutput("abort_flags", {61'd0, done8, busy8, err8}, 64'd0);
        wait_cycle();
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            wait_cycle();
            if (done8) dones++;
        end
        checkOutput("abort_no_done", 64'(dones), 64'd0);

        for (int i = 0; i < 12; i++) begin
            m = 2 * int'($urandom_range(1, 7)) + 1;
            a = int'($urandom_range(0, m - 1));
            b = int'($urandom_range(0, m - 1));
            run_op("rand4", 0, a, b, m);
        end
        for (int i = 0; i < 12; i++) begin
            m = 2 * int'($urandom_range(1, 127)) + 1;
            a = int'($urandom_range(0, m - 1));
            b = int'($urandom_range(0, m - 1));
            run_op("rand8", 1, a, b, m);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
